snake_matrix_scan: RTL

SNAKE_MATRIX_SCAN -- requirements
Module: snake_matrix_scan

---
 rtl/snake_pkg.sv | 56 +++++
 rtl/snake_cell_decode.sv | 23 ++
 rtl/snake_matrix_scan.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants, state encoding and colour types for the snake LED matrix scanner.
package snake_pkg;

  localparam int unsigned GRID_W      = 10;
  localparam int unsigned IDX_MIN     = 12;
  localparam int unsigned IDX_MAX     = 89;
  localparam int unsigned COL_OFS     = 2;
  localparam int unsigned ROW_OFS     = 1;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned N_ROWS      = 8;
  localparam int unsigned N_BODY      = 8;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BUILD_STEPS = 11;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_BUILD,
    ST_SHOW,
    ST_BLANK
  } scan_state_t;

  typedef struct packed {
    logic red;
    logic green;
  } colour_t;

  localparam colour_t CLR_OFF   = '{red: 1'b0, green: 1'b0};
  localparam colour_t CLR_RED   = '{red: 1'b1, green: 1'b0};
  localparam colour_t CLR_GREEN = '{red: 1'b0, green: 1'b1};
  localparam colour_t CLR_AMBER = '{red: 1'b1, green: 1'b1};

  // Per-frame copy of the game inputs; body[7] is the cell in snake[63:56].
  typedef struct packed {
    logic [IDX_W-1:0]             head;
    logic [N_BODY-1:0][IDX_W-1:0] body;
    logic [IDX_W-1:0]             apple;
    logic [IDX_W-1:0]             barrier;
    logic                         dead;
    logic                         win;
  } frame_snap_t;

  // Win recolours every lit source green; otherwise game-over recolours it red.
  function automatic colour_t apply_mode(input colour_t c, input logic win, input logic dead);
    colour_t o;
    o = c;
    if (c != CLR_OFF) begin
      if (win) begin
        o = CLR_GREEN;
      end else if (dead) begin
        o = CLR_RED;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/snake_cell_decode.sv
// Maps a linear game cell index (row-major, 10 wide, with border) to matrix row/column.
module snake_cell_decode
  import snake_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic             valid_c,
  output logic [2:0]       row_c,
  output logic [2:0]       col_c
);

  logic [IDX_W-1:0] tens;
  logic [IDX_W-1:0] units;

  always_comb begin
    tens    = idx / IDX_W'(GRID_W);
    units   = idx % IDX_W'(GRID_W);
    valid_c = (idx >= IDX_W'(IDX_MIN)) && (idx <= IDX_W'(IDX_MAX)) &&
              (units >= IDX_W'(COL_OFS));
    row_c   = 3'(tens - IDX_W'(ROW_OFS));
    col_c   = 3'(units - IDX_W'(COL_OFS));
  end

endmodule

// File: rtl/snake_matrix_scan.sv
// Row-multiplexed 8x8 red/green LED scanner for the snake game display.
// Optional apple blinking is enabled by defining SNAKE_SCAN_BLINK_EN.
module snake_matrix_scan
  import snake_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 25000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [71:0] snake,
  input  logic [7:0]  apple,
  input  logic [7:0]  barrier,
  input  logic        dead_flag,
  input  logic        win_flag,
  output logic [7:0]  row,
  output logic [7:0]  col_r,
  output logic [7:0]  col_g,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUILD_LAST = CNT_W'(BUILD_STEPS - 1);

  scan_state_t      state, state_d;
  logic [2:0]       row_cnt, row_cnt_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  frame_snap_t      snap, snap_d;
  logic [7:0]       pat_r, pat_r_d;
  logic [7:0]       pat_g, pat_g_d;
  logic [7:0]       row_d, col_r_d, col_g_d;
  logic             frame_start_d;

`ifdef SNAKE_SCAN_BLINK_EN
  logic [4:0]       frame_cnt, frame_cnt_d;
  logic             apple_off, apple_off_d;
`endif

  logic [IDX_W-1:0] src_idx;
  colour_t          src_clr;
  colour_t          src_mode;
  logic             dec_valid;
  logic [2:0]       dec_row;
  logic [2:0]       dec_col;
  logic             hit;
  logic [7:0]       col_oh;

  // Source selected by BUILD step: 0 head, 1..8 body[7..0], 9 apple, 10 barrier.
  always_comb begin
    src_idx = '0;
    src_clr = CLR_OFF;
    case (cnt[3:0])
      4'd0: begin
        src_idx = snap.head;
        src_clr = CLR_AMBER;
      end
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        src_idx = snap.body[3'(4'd8 - cnt[3:0])];
        src_clr = CLR_GREEN;
      end
      4'd9: begin
        src_idx = snap.apple;
`ifdef SNAKE_SCAN_BLINK_EN
        src_clr = apple_off ? CLR_OFF : CLR_RED;
`else
        src_clr = CLR_RED;
`endif
      end
      4'd10: begin
        src_idx = snap.barrier;
        src_clr = CLR_RED;
      end
      default: ;
    endcase
  end

  snake_cell_decode u_decode (
    .idx     (src_idx),
    .valid_c (dec_valid),
    .row_c   (dec_row),
    .col_c   (dec_col)
  );

  always_comb begin
    src_mode = apply_mode(src_clr, snap.win, snap.dead);
    hit      = dec_valid && (dec_row == row_cnt);
    col_oh   = 8'(1) << dec_col;
  end

  // Next-state, datapath and output decode; outputs follow the next state.
  always_comb begin
    state_d       = state;
    row_cnt_d     = row_cnt;
    cnt_d         = cnt;
    snap_d        = snap;
    pat_r_d       = pat_r;
    pat_g_d       = pat_g;
    frame_start_d = 1'b0;
    row_d         = '0;
    col_r_d       = '0;
    col_g_d       = '0;
`ifdef SNAKE_SCAN_BLINK_EN
    frame_cnt_d   = frame_cnt;
    apple_off_d   = apple_off;
`endif

    case (state)
      ST_LOAD: begin
        snap_d.head    = snake[71:64];
        snap_d.body    = snake[63:0];
        snap_d.apple   = apple;
        snap_d.barrier = barrier;
        snap_d.dead    = dead_flag;
        snap_d.win     = win_flag;
        frame_start_d  = 1'b1;
        cnt_d          = '0;
        state_d        = ST_BUILD;
`ifdef SNAKE_SCAN_BLINK_EN
        apple_off_d    = frame_cnt[4];
        frame_cnt_d    = frame_cnt + 5'd1;
`endif
      end
      ST_BUILD: begin
        if (cnt[3:0] == 4'd0) begin
          pat_r_d = '0;
          pat_g_d = '0;
        end
        if (hit) begin
          if (src_mode.red) pat_r_d = pat_r_d | col_oh;
          if (src_mode.green) pat_g_d = pat_g_d | col_oh;
        end
        if (cnt == BUILD_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_d     = '0;
          row_cnt_d = row_cnt + 3'd1;
          state_d   = (row_cnt == 3'd7) ? ST_LOAD : ST_BUILD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (state_d == ST_SHOW) begin
      row_d   = 8'(1) << row_cnt_d;
      col_r_d = pat_r_d;
      col_g_d = pat_g_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_LOAD;
      row_cnt     <= '0;
      cnt         <= '0;
      snap        <= '0;
      pat_r       <= '0;
      pat_g       <= '0;
      row         <= '0;
      col_r       <= '0;
      col_g       <= '0;
      frame_start <= 1'b0;
`ifdef SNAKE_SCAN_BLINK_EN
      frame_cnt   <= '0;
      apple_off   <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      row_cnt     <= row_cnt_d;
      cnt         <= cnt_d;
      snap        <= snap_d;
      pat_r       <= pat_r_d;
      pat_g       <= pat_g_d;
      row         <= row_d;
      col_r       <= col_r_d;
      col_g       <= col_g_d;
      frame_start <= frame_start_d;
`ifdef SNAKE_SCAN_BLINK_EN
      frame_cnt   <= frame_cnt_d;
      apple_off   <= apple_off_d;
`endif
    end
  end

endmodule
